bus_control_sequencer: RTL and testbench

Multi-cycle hardwired control unit for the single-bus datapath: PC, IR, MAR, MDR, Y, Z and the general registers. Steps through fetch (T0-T2) and execute (T3-T7) states. Drives one-hot register-in/out strobes, ALU op, memory Read/Write and general-register select onto the shared bus. Only one bus driver is asserted per cycle. Memory accesses use a ready handshake with timeout.

---
 rtl/bus_control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_bus_control_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_control_sequencer.sv
// Hardwired multi-cycle control unit for the single-bus datapath: fetch T0-T2, execute T3-T7.
// Optional SINGLE_STEP_EN adds step/waiting ports and parks in IDLE before every fetch.
module bus_control_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int RSEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SINGLE_STEP_EN
  input  logic              step,
  output logic              waiting,
`endif
  input  logic [31:0]       IR_q,
  input  logic              mem_ready,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Cout,
  output logic              Read,
  output logic              Write,
  output logic              Rin,
  output logic              Rout,
  output logic [RSEL_W-1:0] rsel,
  output logic [3:0]        alu_op,
  output logic              run,
  output logic              illegal_op,
  output logic              mem_fault,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,  S_T0  = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
    S_T3   = 4'd4,  S_T4  = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
    S_T7   = 4'd8,  S_T7W = 4'd9, S_IDLE = 4'd10, S_HLT = 4'd15
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            cur, nxt, done_st;
  logic [7:0]        cnt;
  logic              set_illegal, wait_st, timed_out;
  logic [4:0]        op;
  logic              is_alu, is_addi, is_ld, is_st, is_nop, is_halt, uses_imm;
  logic [RSEL_W-1:0] ra, rb, rc;
  logic              unused_ir;

  assign op       = IR_q[31:27];
  assign ra       = RSEL_W'(IR_q[26:23]);
  assign rb       = RSEL_W'(IR_q[22:19]);
  assign rc       = RSEL_W'(IR_q[18:15]);
  assign unused_ir = ^IR_q[14:0];
  assign is_alu   = (op <= 5'd3);
  assign is_addi  = (op == 5'd4);
  assign is_ld    = (op == 5'd5);
  assign is_st    = (op == 5'd6);
  assign is_nop   = (op == 5'd24);
  assign is_halt  = (op == 5'd27);
  assign uses_imm = is_addi | is_ld | is_st;

  // T6 only waits on memory for loads; the store half of T6 is a plain bus transfer.
  assign wait_st   = (cur == S_T1) || (cur == S_T6 && !is_st) || (cur == S_T7W);
  assign timed_out = wait_st && !mem_ready && (cnt == TO_LAST);
  assign run       = (cur != S_HLT);
  assign state     = cur;

`ifdef SINGLE_STEP_EN
  logic step_q, step_rise;
  assign step_rise = step & ~step_q;
  assign done_st   = S_IDLE;
  assign waiting   = (cur == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end
`else
  assign done_st = S_T0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= S_RST;
      cnt        <= '0;
      illegal_op <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)                 cnt <= '0;
      else if (wait_st && !mem_ready) cnt <= cnt + 8'd1;
      if (set_illegal) illegal_op <= 1'b1;
      if (timed_out)   mem_fault  <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    set_illegal = 1'b0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout} = '0;
    {Read, Write, Rin, Rout} = '0;
    rsel   = '0;
    alu_op = 4'd0;
    case (cur)
      S_RST: nxt = done_st;
      S_IDLE: begin
`ifdef SINGLE_STEP_EN
        if (step_rise) nxt = S_T0;
`else
        nxt = S_T0;
`endif
      end
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = 4'b1111;
        alu_op = 4'd4;
        nxt = S_T1;
      end
      S_T1: begin
        {Zlowout, Read, MDRin} = 3'b111;
        PCin = (cnt == 8'd0);
        if (mem_ready)      nxt = S_T2;
        else if (timed_out) nxt = S_HLT;
      end
      S_T2: begin
        {MDRout, IRin} = 2'b11;
        nxt = S_T3;
      end
      S_T3: begin
        if (is_alu || uses_imm) begin
          rsel = rb;
          {Rout, Yin} = 2'b11;
          nxt = S_T4;
        end else if (is_nop) begin
          nxt = done_st;
        end else begin
          set_illegal = !is_halt;
          nxt = S_HLT;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_alu) begin
          rsel   = rc;
          Rout   = 1'b1;
          alu_op = {2'b00, op[1:0]};
        end else begin
          Cout = 1'b1;
        end
        nxt = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1;
          nxt = S_T6;
        end else begin
          rsel = ra;
          Rin  = 1'b1;
          nxt  = done_st;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) begin
          rsel = ra;
          Rout = 1'b1;
          nxt  = S_T7W;
        end else begin
          Read = 1'b1;
          if (mem_ready)      nxt = S_T7;
          else if (timed_out) nxt = S_HLT;
        end
      end
      S_T7: begin
        {MDRout, Rin} = 2'b11;
        rsel = ra;
        nxt  = done_st;
      end
      S_T7W: begin
        Write = 1'b1;
        if (mem_ready)      nxt = done_st;
        else if (timed_out) nxt = S_HLT;
      end
      S_HLT:   nxt = S_HLT;
      default: nxt = S_HLT;
    endcase
  end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Scoreboard bench for bus_control_sequencer: stimulus queues the expected per-cycle outputs,
// a negedge monitor pops and compares them against the full output vector.
module tb_bus_control_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] IR_q;
  logic        mem_ready;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic        Read, Write, Rin, Rout;
  logic [3:0]  rsel, alu_op, state;
  logic        run, illegal_op, mem_fault;
`ifdef SINGLE_STEP_EN
  logic        step, waiting;
`endif

  bus_control_sequencer #(.TIMEOUT(8), .RSEL_W(4)) dut (
    .clk(clk), .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(step), .waiting(waiting),
`endif
    .IR_q(IR_q), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
    .Read(Read), .Write(Write), .Rin(Rin), .Rout(Rout), .rsel(rsel), .alu_op(alu_op),
    .run(run), .illegal_op(illegal_op), .mem_fault(mem_fault), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [14:0] B_PCOUT = 15'h4000, B_PCIN  = 15'h2000, B_INCPC = 15'h1000;
  localparam logic [14:0] B_MARIN = 15'h0800, B_MDRIN = 15'h0400, B_MDROUT = 15'h0200;
  localparam logic [14:0] B_IRIN  = 15'h0100, B_YIN   = 15'h0080, B_ZIN   = 15'h0040;
  localparam logic [14:0] B_ZLOW  = 15'h0020, B_COUT  = 15'h0010, B_READ  = 15'h0008;
  localparam logic [14:0] B_WRITE = 15'h0004, B_RIN   = 15'h0002, B_ROUT  = 15'h0001;

  logic [29:0] got;
  assign got = {state, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                Cout, Read, Write, Rin, Rout, rsel, alu_op, run, illegal_op, mem_fault};

  logic [29:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_on = 1'b0;
  logic        done = 1'b0;
  logic        final_done = 1'b0;
  logic        bg;
  logic [29:0] ex;
  string       nm;
  int          drivers;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL %s: got state=%0d strobes=%b rsel=%0d alu=%0d run/ill/flt=%b, expected state=%0d strobes=%b rsel=%0d alu=%0d run/ill/flt=%b",
                 nm, got[29:26], got[25:11], got[10:7], got[6:3], got[2:0],
                 ex[29:26], ex[25:11], ex[10:7], ex[6:3], ex[2:0]);
      end
    end
    if (mon_on) begin
      drivers = int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Rout) + int'(Cout);
      checks++;
      if (drivers > 1) begin
        failures++;
        $display("FAIL bus_exclusive: got %0d bus drivers in state %0d, expected at most 1", drivers, state);
      end
    end
    if (done && !final_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
      end
      final_done = 1'b1;
    end
  end

  function automatic logic [29:0] ev(input logic [3:0] st, input logic [14:0] sb, input logic [3:0] rs,
                                     input logic [3:0] al, input logic rn, input logic il, input logic fl);
    return {st, sb, rs, al, rn, il, fl};
  endfunction

  function automatic logic [29:0] en(input logic [3:0] st, input logic [14:0] sb, input logic [3:0] rs,
                                     input logic [3:0] al);
    return ev(st, sb, rs, al, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic cyc(input string n, input logic [29:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic t0();
`ifdef SINGLE_STEP_EN
    step = 1'b1;
    mem_ready = bg;
    cyc("idle", en(4'd10, 15'h0, 4'd0, 4'd0));
    step = 1'b0;
`endif
    mem_ready = bg;
    cyc("t0", en(4'd1, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 4'd0, 4'd4));
  endtask

  task automatic fetch(input int waits);
    t0();
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      cyc("t1", en(4'd2, B_ZLOW | B_READ | B_MDRIN | ((i == 0) ? B_PCIN : 15'h0), 4'd0, 4'd0));
    end
    mem_ready = bg;
    cyc("t2", en(4'd3, B_MDROUT | B_IRIN, 4'd0, 4'd0));
  endtask

  task automatic exec_alu(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    mem_ready = bg;
    cyc("alu_t3", en(4'd4, B_ROUT | B_YIN, rb, 4'd0));
    cyc("alu_t4", en(4'd5, B_ROUT | B_ZIN, rc, op));
    cyc("alu_t5", en(4'd6, B_ZLOW | B_RIN, ra, 4'd0));
  endtask

  task automatic imm_t3_t4(input logic [3:0] rb);
    mem_ready = bg;
    cyc("imm_t3", en(4'd4, B_ROUT | B_YIN, rb, 4'd0));
    cyc("imm_t4", en(4'd5, B_COUT | B_ZIN, 4'd0, 4'd0));
  endtask

  task automatic exec_addi(input logic [3:0] ra, input logic [3:0] rb);
    imm_t3_t4(rb);
    cyc("addi_t5", en(4'd6, B_ZLOW | B_RIN, ra, 4'd0));
  endtask

  task automatic exec_ld(input logic [3:0] ra, input logic [3:0] rb, input int waits);
    imm_t3_t4(rb);
    cyc("ld_t5", en(4'd6, B_ZLOW | B_MARIN, 4'd0, 4'd0));
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      cyc("ld_t6", en(4'd7, B_READ | B_MDRIN, 4'd0, 4'd0));
    end
    mem_ready = bg;
    cyc("ld_t7", en(4'd8, B_MDROUT | B_RIN, ra, 4'd0));
  endtask

  task automatic exec_st(input logic [3:0] ra, input logic [3:0] rb, input int waits);
    imm_t3_t4(rb);
    cyc("st_t5", en(4'd6, B_ZLOW | B_MARIN, 4'd0, 4'd0));
    mem_ready = 1'b1;
    cyc("st_t6", en(4'd7, B_ROUT | B_MDRIN, ra, 4'd0));
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      cyc("st_t7w", en(4'd9, B_WRITE, 4'd0, 4'd0));
    end
    mem_ready = bg;
  endtask

  task automatic reset_from_halt(input string n, input logic [29:0] hlt);
    reset = 1'b1;
    cyc(n, hlt);
    reset = 1'b0;
    cyc("reset_clears_flags", ev(4'd0, 15'h0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    IR_q = 32'h0;
    bg = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_on = 1'b1;
    cyc("reset_state", ev(4'd0, 15'h0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));

    // ADD R1,R1,R1 with memory always ready
    bg = 1'b1;
    IR_q = 32'h00888000; fetch(0); exec_alu(4'd0, 4'd1, 4'd1, 4'd1);
    bg = 1'b0;
    IR_q = 32'h091A0000; fetch(3); exec_alu(4'd1, 4'd2, 4'd3, 4'd4);
    IR_q = 32'h12B38000; fetch(0); exec_alu(4'd2, 4'd5, 4'd6, 4'd7);
    IR_q = 32'h18000000; fetch(1); exec_alu(4'd3, 4'd0, 4'd0, 4'd0);
    IR_q = 32'h21900000; fetch(0); exec_addi(4'd3, 4'd2);
    IR_q = 32'h2B480000; fetch(0); exec_ld(4'd6, 4'd9, 1);
    IR_q = 32'h35080000; fetch(0); exec_st(4'd10, 4'd1, 1);
    IR_q = 32'hC0000000; fetch(0);
    mem_ready = 1'b1;
    cyc("nop_t3", en(4'd4, 15'h0, 4'd0, 4'd0));

    // reset lands while T1 is reading
    t0();
    mem_ready = 1'b0;
    reset = 1'b1;
    cyc("t1_before_reset", en(4'd2, B_ZLOW | B_READ | B_MDRIN | B_PCIN, 4'd0, 4'd0));
    reset = 1'b0;
    cyc("reset_mid_t1", ev(4'd0, 15'h0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));

    // memory never answers: eight wait cycles then fault
    t0();
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b0;
      cyc("timeout_wait", en(4'd2, B_ZLOW | B_READ | B_MDRIN | ((i == 0) ? B_PCIN : 15'h0), 4'd0, 4'd0));
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i % 2 == 1);
      cyc("timeout_hlt", ev(4'd15, 15'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    end
    reset_from_halt("timeout_hlt", ev(4'd15, 15'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));

    IR_q = 32'hF8000000; fetch(0);
    cyc("illegal_t3", en(4'd4, 15'h0, 4'd0, 4'd0));
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i % 2 == 0);
      cyc("illegal_hlt", ev(4'd15, 15'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    end
    reset_from_halt("illegal_hlt", ev(4'd15, 15'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));

    IR_q = 32'hD8000000; fetch(0);
    cyc("halt_t3", en(4'd4, 15'h0, 4'd0, 4'd0));
    cyc("halt_hlt", ev(4'd15, 15'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    reset_from_halt("halt_hlt", ev(4'd15, 15'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    IR_q = 32'h00888000; fetch(0); exec_alu(4'd0, 4'd1, 4'd1, 4'd1);
    mem_ready = 1'b0;
    t0();

    done = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
